// File: rtl/qc_ldpc_bf_decoder.sv
// rtl/qc_ldpc_bf_decoder.sv - QC-LDPC hard-decision bit-flipping decoder
// Loads a codeword, iterates syndrome/flip rounds against a shift-value ROM, then streams the info blocks.
module qc_ldpc_bf_decoder #(
    parameter int Z               = 54,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int MAX_ITER        = 8,
    parameter int FLIP_THRESH     = 2,
    localparam int TOTAL_BLKS     = NUM_INFO_BLKS + NUM_PARITY_BLKS,
    localparam int DEPTH          = TOTAL_BLKS * NUM_PARITY_BLKS,
    localparam int AW             = $clog2(DEPTH),
    localparam int SW             = $clog2(Z) + 1,
    localparam int IW             = $clog2(MAX_ITER + 1)
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic [Z-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] rom_addr,
    input  logic [SW-1:0] rom_data,
    output logic [Z-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          dec_ok,
    output logic [IW-1:0] dec_iters
);

    localparam int CW = (TOTAL_BLKS > 1) ? $clog2(TOTAL_BLKS) : 1;
    localparam int RW = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SYND, CHECK, FLIP, OUT} state_t;

    state_t        state;
    logic [Z-1:0]  cw [TOTAL_BLKS];
    logic [Z-1:0]  s [NUM_PARITY_BLKS];
    logic [2:0]    cnt [Z];
    logic [2:0]    cnt_next [Z];
    logic [Z-1:0]  flip_mask;
    logic [Z-1:0]  contrib;
    logic [CW-1:0] blk_cnt;
    logic [CW-1:0] c_cnt;
    logic [RW-1:0] r_cnt;
    logic [CW-1:0] out_idx;
    logic [CW-1:0] out_nxt;
    logic [IW-1:0] iter;
    logic          synd_nz;
    logic          r_last;
    logic          c_last;
    logic          rom_null;
    logic [SW-2:0] shift;

    // rotl(x,k)[i] = x[(i-k) mod Z]; pulling the window out of {x,x} avoids a modulo.
    function automatic logic [Z-1:0] rotl(input logic [Z-1:0] x, input logic [SW-2:0] k);
        logic [2*Z-1:0] d;
        d = {x, x} >> (Z - int'(k));
        return d[Z-1:0];
    endfunction

    function automatic logic [Z-1:0] rotr(input logic [Z-1:0] x, input logic [SW-2:0] k);
        logic [2*Z-1:0] d;
        d = {x, x} >> k;
        return d[Z-1:0];
    endfunction

    assign rom_null = rom_data[SW-1];
    assign shift    = rom_data[SW-2:0];
    assign r_last   = (r_cnt == RW'(NUM_PARITY_BLKS - 1));
    assign c_last   = (c_cnt == CW'(TOTAL_BLKS - 1));
    assign out_nxt  = out_idx + 1'b1;
    assign rom_addr = (state == SYND || state == FLIP) ?
                      AW'(int'(r_cnt) * TOTAL_BLKS + int'(c_cnt)) : '0;

    always_comb begin
        synd_nz = 1'b0;
        for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
            synd_nz = synd_nz | (|s[r]);
        end
    end

    // Per-bit vote of unsatisfied checks for the column currently being scanned.
    always_comb begin
        contrib = rom_null ? '0 : rotr(s[r_cnt], shift);
        for (int j = 0; j < Z; j++) begin
            cnt_next[j]  = cnt[j] + {2'b00, contrib[j]};
            flip_mask[j] = (cnt_next[j] >= 3'(FLIP_THRESH));
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            dec_ok    <= 1'b0;
            dec_iters <= '0;
            blk_cnt   <= '0;
            c_cnt     <= '0;
            r_cnt     <= '0;
            out_idx   <= '0;
            iter      <= '0;
            for (int i = 0; i < TOTAL_BLKS; i++) cw[i] <= '0;
            for (int r = 0; r < NUM_PARITY_BLKS; r++) s[r] <= '0;
            for (int j = 0; j < Z; j++) cnt[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        cw[blk_cnt] <= in_data;
                        if (blk_cnt == CW'(TOTAL_BLKS - 1)) begin
                            blk_cnt  <= '0;
                            in_ready <= 1'b0;
                            state    <= SYND;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end
                end
                SYND: begin
                    if (!rom_null) s[r_cnt] <= s[r_cnt] ^ rotl(cw[c_cnt], shift);
                    if (r_last) begin
                        r_cnt <= '0;
                        if (c_last) begin
                            c_cnt <= '0;
                            state <= CHECK;
                        end else begin
                            c_cnt <= c_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (!synd_nz || iter == IW'(MAX_ITER)) begin
                        dec_ok    <= !synd_nz;
                        dec_iters <= iter;
                        out_valid <= 1'b1;
                        out_data  <= cw[0];
                        out_last  <= (NUM_INFO_BLKS == 1);
                        out_idx   <= '0;
                        state     <= OUT;
                    end else begin
                        iter  <= iter + 1'b1;
                        state <= FLIP;
                    end
                end
                FLIP: begin
                    // The syndrome stays frozen for the whole round; only cw changes.
                    if (r_last) begin
                        cw[c_cnt] <= cw[c_cnt] ^ flip_mask;
                        for (int j = 0; j < Z; j++) cnt[j] <= '0;
                        r_cnt <= '0;
                        if (c_last) begin
                            c_cnt <= '0;
                            for (int r = 0; r < NUM_PARITY_BLKS; r++) s[r] <= '0;
                            state <= SYND;
                        end else begin
                            c_cnt <= c_cnt + 1'b1;
                        end
                    end else begin
                        for (int j = 0; j < Z; j++) cnt[j] <= cnt_next[j];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            dec_ok    <= 1'b0;
                            dec_iters <= '0;
                            iter      <= '0;
                            blk_cnt   <= '0;
                            out_idx   <= '0;
                            for (int r = 0; r < NUM_PARITY_BLKS; r++) s[r] <= '0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            out_idx  <= out_nxt;
                            out_data <= cw[out_nxt];
                            out_last <= (out_nxt == CW'(NUM_INFO_BLKS - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qc_ldpc_bf_decoder.sv
// tb/tb_qc_ldpc_bf_decoder.sv - scoreboard bench for qc_ldpc_bf_decoder
module tb_qc_ldpc_bf_decoder;

    localparam int Z     = 54;
    localparam int NI    = 20;
    localparam int NP    = 4;
    localparam int MAXI  = 8;
    localparam int T     = NI + NP;
    localparam int DEPTH = T * NP;
    localparam int AW    = $clog2(DEPTH);
    localparam int SW    = $clog2(Z) + 1;
    localparam int IW    = $clog2(MAXI + 1);
    localparam int LAT0  = DEPTH + 1;
    localparam int LATI  = 2 * DEPTH + 1;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [Z-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rom_addr;
    logic [SW-1:0] rom_data;
    logic [Z-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          dec_ok;
    logic [IW-1:0] dec_iters;

    int n_cmp = 0;
    int n_bad = 0;
    logic [Z-1:0] exp_q [$];
    logic [Z-1:0] cw_tb [T];

    qc_ldpc_bf_decoder #(
        .Z(Z), .NUM_INFO_BLKS(NI), .NUM_PARITY_BLKS(NP), .MAX_ITER(MAXI), .FLIP_THRESH(2)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .dec_ok(dec_ok), .dec_iters(dec_iters)
    );

    always #5 CLK = ~CLK;

    // Info columns: shift (r*c) mod Z, which has no 4-cycles through column 5; parity part is identity.
    function automatic logic [SW-1:0] rom_fn(input logic [AW-1:0] a);
        int r;
        int c;
        r = int'(a) / T;
        c = int'(a) % T;
        if (c < NI) return SW'((r * c) % Z);
        if (c - NI == r) return '0;
        return {1'b1, {(SW-1){1'b0}}};
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    function automatic logic [Z-1:0] ref_rotl(input logic [Z-1:0] x, input int k);
        logic [Z-1:0] y;
        for (int i = 0; i < Z; i++) y[i] = x[(i - k + Z) % Z];
        return y;
    endfunction

    task automatic build_codeword(input bit zero);
        logic [63:0]  rnd;
        logic [Z-1:0] p;
        for (int c = 0; c < NI; c++) begin
            rnd = {$urandom(), $urandom()};
            cw_tb[c] = zero ? '0 : rnd[Z-1:0];
        end
        for (int r = 0; r < NP; r++) begin
            p = '0;
            for (int c = 0; c < NI; c++) p = p ^ ref_rotl(cw_tb[c], (r * c) % Z);
            cw_tb[NI + r] = p;
        end
    endtask

    task automatic push_info();
        for (int c = 0; c < NI; c++) exp_q.push_back(cw_tb[c]);
    endtask

    task automatic send_block(input logic [Z-1:0] d);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        while (!acc && t < 200) begin
            acc = in_ready;
            @(posedge CLK); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic send_codeword(input bit gaps);
        for (int b = 0; b < T; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            send_block(cw_tb[b]);
        end
    endtask

    task automatic collect(input bit chk_data, input bit exp_ok, input int it_min,
                           input int it_max, input int exp_lat, input bit stall);
        int t;
        logic [Z-1:0] hd;
        logic [Z-1:0] ed;
        logic hl;
        logic hok;
        logic [IW-1:0] hit;
        t = 0;
        while (!out_valid && t < 4000) begin
            @(posedge CLK); #1;
            t++;
        end
        if (!out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL out_valid_timeout: waited %0d edges", t);
            return;
        end
        if (exp_lat >= 0) begin
            n_cmp++;
            if (t != exp_lat) begin
                n_bad++;
                $display("FAIL latency: got %0d edges required %0d", t, exp_lat);
            end
        end
        for (int b = 0; b < NI; b++) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL out_valid_blk%0d: got %b required 1", b, out_valid);
            end
            do begin
                out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                hd = out_data; hl = out_last; hok = dec_ok; hit = dec_iters;
                @(posedge CLK); #1;
                if (!out_ready) begin
                    n_cmp++;
                    if ({out_valid, out_data, out_last, dec_ok, dec_iters} !== {1'b1, hd, hl, hok, hit}) begin
                        n_bad++;
                        $display("FAIL stall_stable_blk%0d: got data=%h last=%b required data=%h last=%b",
                                 b, out_data, out_last, hd, hl);
                    end
                end
            end while (!out_ready);
            out_ready = 1'b0;
            if (chk_data) begin
                ed = exp_q.pop_front();
                n_cmp++;
                if (hd !== ed) begin
                    n_bad++;
                    $display("FAIL data_blk%0d: got %h required %h", b, hd, ed);
                end
            end
            n_cmp++;
            if (hl !== 1'(b == NI - 1)) begin
                n_bad++;
                $display("FAIL out_last_blk%0d: got %b required %b", b, hl, (b == NI - 1));
            end
            n_cmp++;
            if (hok !== exp_ok) begin
                n_bad++;
                $display("FAIL dec_ok_blk%0d: got %b required %b", b, hok, exp_ok);
            end
            n_cmp++;
            if (int'(hit) < it_min || int'(hit) > it_max) begin
                n_bad++;
                $display("FAIL dec_iters_blk%0d: got %0d required %0d..%0d", b, hit, it_min, it_max);
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL end_of_codeword: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_last, dec_ok} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 0000", {in_ready, out_valid, out_last, dec_ok});
        end
        n_cmp++;
        if (out_data !== '0 || dec_iters !== '0 || rom_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_buses: data=%h iters=%0d addr=%0d required 0", out_data, dec_iters, rom_addr);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_to_load: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_zero_codeword();
        build_codeword(1'b1);
        push_info();
        send_codeword(1'b0);
        collect(1'b1, 1'b1, 0, 0, LAT0, 1'b0);
    endtask

    task automatic test_clean_codeword();
        build_codeword(1'b0);
        push_info();
        send_codeword(1'b0);
        collect(1'b1, 1'b1, 0, 0, LAT0, 1'b0);
    endtask

    task automatic test_single_error();
        build_codeword(1'b0);
        push_info();
        cw_tb[5][10] = ~cw_tb[5][10];
        send_codeword(1'b0);
        collect(1'b1, 1'b1, 1, MAXI, -1, 1'b0);
    endtask

    task automatic test_heavy_errors();
        build_codeword(1'b0);
        for (int b = 0; b < T; b++)
            for (int j = 0; j < Z; j++)
                if ($urandom_range(0, 99) < 30) cw_tb[b][j] = ~cw_tb[b][j];
        send_codeword(1'b0);
        collect(1'b0, 1'b0, MAXI, MAXI, LAT0 + MAXI * LATI, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            build_codeword(1'b0);
            push_info();
            send_codeword(1'b1);
            collect(1'b1, 1'b1, 0, 0, LAT0, 1'b1);
        end
    endtask

    task automatic test_reset_mid_flip();
        build_codeword(1'b0);
        push_info();
        cw_tb[5][10] = ~cw_tb[5][10];
        send_codeword(1'b0);
        repeat (LAT0 + 50) @(posedge CLK);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_last, dec_ok} !== 4'b0000 || out_data !== '0 ||
            dec_iters !== '0 || rom_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_flip: rdy=%b vld=%b data=%h addr=%0d required all 0",
                     in_ready, out_valid, out_data, rom_addr);
        end
        exp_q.delete();
        @(posedge CLK); #1;
        rst_n = 1'b1;
        build_codeword(1'b0);
        push_info();
        send_codeword(1'b0);
        collect(1'b1, 1'b1, 0, 0, LAT0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_codeword();
        test_clean_codeword();
        test_single_error();
        test_heavy_errors();
        test_back_to_back();
        test_reset_mid_flip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
